// File: rtl/dram_rst_pkg.sv
// Shared types and sizing helpers for the DRAM clock-domain reset sequencer.
package dram_rst_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STRETCH,
        RELEASE,
        CAL,
        READY,
        FAIL
    } seq_state_e;

    localparam int unsigned RELOCK_MAX = 255;

    // Width that can hold the terminal count itself, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal < 2) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/dram_lock_filter.sv
// Two-flop synchroniser for the clock-manager lock, followed by a saturating
// run-length filter that only trusts lock after LOCK_FILTER high cycles.
module dram_lock_filter
    import dram_rst_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic lock_async_i,
    output logic lock_sync_o,
    output logic lock_ok_o
);

    localparam int unsigned   FW       = cnt_width(LOCK_FILTER);
    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);

    logic [1:0]    sync_q;
    logic [FW-1:0] filt_q;
    logic [FW-1:0] filt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            filt_q <= '0;
        end else begin
            sync_q <= {sync_q[0], lock_async_i};
            filt_q <= filt_d;
        end
    end

    // NOTE: default assigned first so no path leaves filt_d unassigned and infers a latch.
    always_comb begin
        filt_d = filt_q;
        if (!sync_q[1]) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + 1'b1;
        end
    end

    assign lock_sync_o = sync_q[1];
    // Drops in the same cycle the synchronised lock goes low.
    assign lock_ok_o   = sync_q[1] && (filt_q == FILT_MAX);

endmodule

// File: rtl/dram_reset_sequencer.sv
// Staggered reset release, calibration hand-off and relock tracking for the
// DRAM clock domain. All outputs come straight from flops.
module dram_reset_sequencer
    import dram_rst_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 300,
    parameter int unsigned NUM_RST        = 3,
    parameter int unsigned LOCK_FILTER    = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned CAL_TIMEOUT    = 65535
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               clk_in_locked,
    output logic [NUM_RST-1:0] rst_out,
    output logic               cal_start,
    input  logic               cal_done,
    output logic               ready,
    output logic               cal_fail,
    output logic [7:0]         relock_count
);

    if (CLK_FREQ == 0 || NUM_RST < 1 || NUM_RST > 8 || LOCK_FILTER < 1 ||
        STRETCH_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_params
        $error("dram_reset_sequencer: parameter outside legal range");
    end

    // One phase counter is shared by STRETCH, RELEASE and CAL.
    localparam int unsigned   MAX_SG      = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int unsigned   CNT_MAX     = (MAX_SG > CAL_TIMEOUT) ? MAX_SG : CAL_TIMEOUT;
    localparam int unsigned   CW          = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH_CYCLES);
    localparam logic [CW-1:0] GAP_END     = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] CAL_END     = CW'(CAL_TIMEOUT);

    logic lock_sync;
    logic lock_ok;
    logic lock_lost;

    seq_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_RST-1:0] rst_q, rst_d;
    logic               cal_start_q, cal_start_d;
    logic               ready_q, ready_d;
    logic               cal_fail_q, cal_fail_d;
    logic [7:0]         relock_q, relock_d;
    logic               cal_done_q;

    dram_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .clk_in       (clk_in),
        .reset        (reset),
        .lock_async_i (clk_in_locked),
        .lock_sync_o  (lock_sync),
        .lock_ok_o    (lock_ok)
    );

    assign lock_lost = (state_q != WAIT_LOCK) && !lock_sync;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_q       <= '1;
            cal_start_q <= 1'b0;
            ready_q     <= 1'b0;
            cal_fail_q  <= 1'b0;
            relock_q    <= '0;
            cal_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_q       <= rst_d;
            cal_start_q <= cal_start_d;
            ready_q     <= ready_d;
            cal_fail_q  <= cal_fail_d;
            relock_q    <= relock_d;
            cal_done_q  <= (state_q == CAL) && cal_done;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_d       = rst_q;
        cal_start_d = 1'b0;
        ready_d     = ready_q;
        cal_fail_d  = cal_fail_q;
        relock_d    = relock_q;

        if (lock_lost) begin
            state_d    = WAIT_LOCK;
            cnt_d      = '0;
            rst_d      = '1;
            ready_d    = 1'b0;
            cal_fail_d = 1'b0;
            if (relock_q != 8'(RELOCK_MAX)) begin
                relock_d = relock_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    rst_d = '1;
                    cnt_d = '0;
                    if (lock_ok) begin
                        state_d = STRETCH;
                    end
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_END) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        rst_d   = rst_q << 1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // Resets release as a thermometer from bit 0 upward, so no bit can re-assert alone.
                RELEASE: begin
                    if (rst_q == '0) begin
                        state_d     = CAL;
                        cnt_d       = '0;
                        cal_start_d = 1'b1;
                    end else if (cnt_q == GAP_END) begin
                        cnt_d = '0;
                        rst_d = rst_q << 1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                CAL: begin
                    if (cal_done_q) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end else if (cnt_q == CAL_END) begin
                        state_d    = FAIL;
                        cal_fail_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY, FAIL: begin
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_out      = rst_q;
    assign cal_start    = cal_start_q;
    assign ready        = ready_q;
    assign cal_fail     = cal_fail_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_dram_reset_sequencer.sv
// Scoreboard bench: a timestamp model of the bring-up sequence predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
`timescale 1ns/1ps
module tb_dram_reset_sequencer;

    localparam int NUM_RST        = 3;
    localparam int LOCK_FILTER    = 4;
    localparam int STRETCH_CYCLES = 16;
    localparam int STAGE_GAP      = 8;
    localparam int CAL_TIMEOUT    = 100;

    // Cycles from the first high lock sample to the first release and to cal_start.
    localparam int T_REL0 = LOCK_FILTER + STRETCH_CYCLES + 3;
    localparam int T_CS   = T_REL0 + (NUM_RST - 1) * STAGE_GAP + 1;
    localparam int MAXC   = 16384;

    typedef struct {
        int                 edge_n;
        logic [NUM_RST-1:0] rst;
        logic               cs;
        logic               rdy;
        logic               fail;
        logic [7:0]         relock;
    } exp_t;

    logic               clk_in        = 1'b0;
    logic               reset         = 1'b0;
    logic               clk_in_locked = 1'b0;
    logic               cal_done      = 1'b0;
    logic [NUM_RST-1:0] rst_out;
    logic               cal_start;
    logic               ready;
    logic               cal_fail;
    logic [7:0]         relock_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    bit lk_hist[MAXC];
    bit cd_hist[MAXC];
    int run_k[MAXC];
    int base     = 0;
    int n        = 0;
    int relock_m = 0;

    always #5 clk_in = ~clk_in;

    dram_reset_sequencer #(
        .CLK_FREQ       (300),
        .NUM_RST        (NUM_RST),
        .LOCK_FILTER    (LOCK_FILTER),
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .STAGE_GAP      (STAGE_GAP),
        .CAL_TIMEOUT    (CAL_TIMEOUT)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .clk_in_locked (clk_in_locked),
        .rst_out       (rst_out),
        .cal_start     (cal_start),
        .cal_done      (cal_done),
        .ready         (ready),
        .cal_fail      (cal_fail),
        .relock_count  (relock_count)
    );

    function automatic bit lk_at(input int i);
        return (i >= base && i >= 0) ? lk_hist[i] : 1'b0;
    endfunction

    // Outputs after edge e_n, from the start k of the lock run the DUT currently sees.
    function automatic exp_t model_at(input int e_n);
        exp_t e;
        int   k, d, last_j;
        bit   done;
        e.edge_n = e_n;
        e.relock = 8'(relock_m);
        e.rst    = '1;
        e.cs     = 1'b0;
        e.rdy    = 1'b0;
        e.fail   = 1'b0;
        if (lk_at(e_n - 2)) begin
            k = run_k[e_n - 2];
            d = e_n - k;
            for (int i = 0; i < NUM_RST; i++) e.rst[i] = (d < T_REL0 + i * STAGE_GAP);
            e.cs   = (d == T_CS);
            done   = 1'b0;
            last_j = (e_n - 1 < k + T_CS + CAL_TIMEOUT) ? e_n - 1 : k + T_CS + CAL_TIMEOUT;
            for (int j = k + T_CS + 1; j <= last_j; j++) if (cd_hist[j]) done = 1'b1;
            e.rdy  = done;
            e.fail = !done && (d >= T_CS + CAL_TIMEOUT + 1);
        end
        return e;
    endfunction

    task automatic step(input bit lk, input bit cd);
        if (n >= MAXC) begin
            $display("FAIL cycle_budget edge=%0d limit=%0d", n, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        clk_in_locked = lk;
        cal_done      = cd;
        @(posedge clk_in);
        lk_hist[n] = lk;
        cd_hist[n] = cd;
        run_k[n]   = (lk && lk_at(n - 1)) ? run_k[n - 1] : n;
        // A lock run long enough to leave WAIT_LOCK counts as a relock event when it ends.
        if (!lk_at(n - 2) && lk_at(n - 3) && (n - 2 - run_k[n - 3]) >= LOCK_FILTER + 1 && relock_m < 255)
            relock_m++;
        exp_q.push_back(model_at(n));
        n++;
        #1;
    endtask

    task automatic hold(input bit lk, input bit cd, input int cycles);
        for (int t = 0; t < cycles; t++) step(lk, cd);
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (rst_out !== '1 || cal_start !== 1'b0 || ready !== 1'b0 || cal_fail !== 1'b0 || relock_count !== 8'd0) begin
            fails++;
            $display("FAIL %s got rst=%b start=%b ready=%b cal_fail=%b relock=%0d expected rst=%b start=0 ready=0 cal_fail=0 relock=0",
                     name, rst_out, cal_start, ready, cal_fail, relock_count, {NUM_RST{1'b1}});
        end
    endtask

    always @(negedge clk_in) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if (rst_out !== mon_e.rst || cal_start !== mon_e.cs || ready !== mon_e.rdy ||
                cal_fail !== mon_e.fail || relock_count !== mon_e.relock) begin
                fails++;
                $display("FAIL edge_%0d got rst=%b start=%b ready=%b cal_fail=%b relock=%0d expected rst=%b start=%b ready=%b cal_fail=%b relock=%0d",
                         mon_e.edge_n, rst_out, cal_start, ready, cal_fail, relock_count,
                         mon_e.rst, mon_e.cs, mon_e.rdy, mon_e.fail, mon_e.relock);
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_values("reset_state");
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;

        // Clean bring-up with a calibration pulse at edge 60.
        hold(1'b1, 1'b0, 60);
        step(1'b1, 1'b1);
        hold(1'b1, 1'b0, 20);

        // Lock loss in READY, then the full sequence again.
        step(1'b0, 1'b0);
        hold(1'b1, 1'b0, 55);
        step(1'b1, 1'b1);
        hold(1'b1, 1'b0, 10);

        // Glitchy lock followed by a calibration timeout.
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 3);
        step(1'b0, 1'b0);
        hold(1'b1, 1'b0, 160);

        // Lock loss and cal_done in the same cycle: lock loss must win.
        hold(1'b0, 1'b0, 3);
        hold(1'b1, 1'b0, 50);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        hold(1'b1, 1'b0, 20);
        hold(1'b0, 1'b0, 2);

        // Random lock runs and sparse calibration completions.
        for (int r = 0; r < 40; r++) begin
            int hi_len;
            hi_len = $urandom_range(1, 200);
            for (int t = 0; t < hi_len; t++) step(1'b1, $urandom_range(0, 59) == 0);
            hold(1'b0, ($urandom_range(0, 1) == 1), $urandom_range(1, 3));
        end

        // Relock counter saturation.
        for (int r = 0; r < 300; r++) begin
            hold(1'b1, 1'b0, LOCK_FILTER + 2);
            step(1'b0, 1'b0);
        end
        hold(1'b0, 1'b0, 3);

        // Asynchronous reset in the middle of RELEASE.
        hold(1'b1, 1'b0, T_REL0 + 7);
        #1 reset = 1'b1;
        #1 check_reset_values("async_reset_mid_release");
        exp_q.delete();
        @(posedge clk_in);
        #1 reset = 1'b0;
        base     = n;
        relock_m = 0;

        // Normal bring-up after the reset.
        hold(1'b1, 1'b0, 50);
        step(1'b1, 1'b1);
        hold(1'b1, 1'b0, 5);

        @(negedge clk_in);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
